// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage holding the PC, fetching over a one-outstanding ready/valid imem port and driving the IF/ID register; optional macro IF_MISALIGN_TRAP_EN adds misalign_trap. Ports: clk, reset, imem_req/addr/ready/rvalid/rdata, stall_ID, flush_ID, redirect_en/pc, instruction_IFID, pc_IFID, pc_4_IFID, valid_IFID.
module instruction_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP_INST = 'h13
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall_ID,
  input  logic             flush_ID,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] instruction_IFID,
  output logic [WIDTH-1:0] pc_IFID,
  output logic [WIDTH-1:0] pc_4_IFID,
  output logic             valid_IFID
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap
`endif
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, hold_q, hold_d, inst_q, inst_d, pcid_q, pcid_d, pc4_q, pc4_d;
  logic             valid_q, valid_d, load;
  logic [WIDTH-1:0] load_data, pc_inc, target;
  assign pc_inc    = pc_q + WIDTH'(4);
  assign target    = {redirect_pc[WIDTH-1:2], 2'b00};
  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign instruction_IFID = inst_q;
  assign pc_IFID    = pcid_q;
  assign pc_4_IFID  = pc4_q;
  assign valid_IFID = valid_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    inst_d    = inst_q;
    pcid_d    = pcid_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    load      = 1'b0;
    load_data = hold_q;
    if (redirect_en) begin
      pc_d    = target;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      case (state_q)
        FETCH: state_d = imem_ready ? DROP : FETCH;
        WAIT:  state_d = imem_rvalid ? FETCH : DROP;
        HOLD:  state_d = FETCH;
        DROP:  state_d = DROP;
      endcase
    end else begin
      case (state_q)
        FETCH: state_d = imem_ready ? WAIT : FETCH;
        WAIT: begin
          // A stalled, occupied IF/ID parks the response in the hold buffer; pc_q stays on its address.
          if (imem_rvalid && (!stall_ID || !valid_q)) begin
            load      = 1'b1;
            load_data = imem_rdata;
          end else if (imem_rvalid) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD:  load = !stall_ID;
        DROP:  state_d = imem_rvalid ? FETCH : DROP;
      endcase
      if (load) begin
        pc_d    = pc_inc;
        state_d = FETCH;
      end
      // Bubbles keep the PC fields; a flushed load still consumes its address.
      if (flush_ID) begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end else if (load) begin
        inst_d  = load_data;
        pcid_d  = pc_q;
        pc4_d   = pc_inc;
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      inst_q  <= NOP_INST;
      pcid_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      inst_q  <= inst_d;
      pcid_q  <= pcid_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
`ifdef IF_MISALIGN_TRAP_EN
  logic trap_q;
  assign misalign_trap = trap_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= redirect_en && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of instruction_fetch against a zero-wait memory model returning addr|0x100.
module tb_instruction_fetch;
  logic        clk = 1'b0, reset = 1'b1, imem_req, imem_ready = 1'b1, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc = '0;
  logic        stall_ID = 1'b0, flush_ID = 1'b0, redirect_en = 1'b0, valid_IFID;
  logic [31:0] instruction_IFID, pc_IFID, pc_4_IFID;
  logic        pend = 1'b0, mem_hold = 1'b0;
  logic [31:0] paddr = '0;
  int          errors = 0, checks = 0;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif
  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_ID(stall_ID), .flush_ID(flush_ID), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .instruction_IFID(instruction_IFID), .pc_IFID(pc_IFID), .pc_4_IFID(pc_4_IFID),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .valid_IFID(valid_IFID)
  );
  always #5 clk = ~clk;
  assign imem_rvalid = pend && !mem_hold;
  assign imem_rdata  = paddr | 32'h100;
  always @(posedge clk) begin
    if (imem_req && imem_ready) begin
      pend  <= 1'b1;
      paddr <= imem_addr;
    end else if (imem_rvalid) pend <= 1'b0;
  end
  task automatic test_reset();
    repeat (2) @(negedge clk);
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end checks++;
    if (instruction_IFID !== 32'h13) begin errors++; $display("FAIL rst_inst: got %h want 00000013", instruction_IFID); end checks++;
    if (valid_IFID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_IFID); end checks++;
    if (pc_IFID !== 32'h0 || pc_4_IFID !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h/%h want 0/0", pc_IFID, pc_4_IFID); end checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end checks++;
    reset = 1'b0;
  endtask
  task automatic test_stream();
    repeat (2) @(negedge clk);
    if (pc_IFID !== 32'h0 || instruction_IFID !== 32'h100 || valid_IFID !== 1'b1 || pc_4_IFID !== 32'h4)
      begin errors++; $display("FAIL stream0: got pc=%h inst=%h v=%b pc4=%h want 0/100/1/4", pc_IFID, instruction_IFID, valid_IFID, pc_4_IFID); end checks++;
    repeat (2) @(negedge clk);
    if (pc_IFID !== 32'h4 || instruction_IFID !== 32'h104 || valid_IFID !== 1'b1 || pc_4_IFID !== 32'h8)
      begin errors++; $display("FAIL stream4: got pc=%h inst=%h v=%b pc4=%h want 4/104/1/8", pc_IFID, instruction_IFID, valid_IFID, pc_4_IFID); end checks++;
  endtask
  task automatic test_stall_hold();
    @(negedge clk);
    if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_wait: got req=%b addr=%h want 0/8", imem_req, imem_addr); end checks++;
    stall_ID = 1'b1;
    repeat (3) @(negedge clk);
    if (pc_IFID !== 32'h4 || instruction_IFID !== 32'h104 || valid_IFID !== 1'b1)
      begin errors++; $display("FAIL stall_keep: got pc=%h inst=%h v=%b want 4/104/1", pc_IFID, instruction_IFID, valid_IFID); end checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_pc: got req=%b addr=%h want 0/8", imem_req, imem_addr); end checks++;
    repeat (2) @(negedge clk);
    stall_ID = 1'b0;
    @(negedge clk);
    if (pc_IFID !== 32'h8 || instruction_IFID !== 32'h108 || pc_4_IFID !== 32'hC || valid_IFID !== 1'b1)
      begin errors++; $display("FAIL hold_rel: got pc=%h inst=%h pc4=%h v=%b want 8/108/c/1", pc_IFID, instruction_IFID, pc_4_IFID, valid_IFID); end checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL hold_next: got req=%b addr=%h want 1/c", imem_req, imem_addr); end checks++;
    repeat (2) @(negedge clk);
    if (pc_IFID !== 32'hC || instruction_IFID !== 32'h10C) begin errors++; $display("FAIL hold_once: got pc=%h inst=%h want c/10c", pc_IFID, instruction_IFID); end checks++;
  endtask
  task automatic test_redirect_wait();
    mem_hold = 1'b1;
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    if (instruction_IFID !== 32'h13 || valid_IFID !== 1'b0 || pc_IFID !== 32'hC)
      begin errors++; $display("FAIL redir_bubble: got inst=%h v=%b pc=%h want 13/0/c", instruction_IFID, valid_IFID, pc_IFID); end checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_drop: got req=%b addr=%h want 0/40", imem_req, imem_addr); end checks++;
    redirect_en = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || valid_IFID !== 1'b0)
      begin errors++; $display("FAIL redir_discard: got req=%b addr=%h v=%b want 1/40/0", imem_req, imem_addr, valid_IFID); end checks++;
    repeat (2) @(negedge clk);
    if (pc_IFID !== 32'h40 || instruction_IFID !== 32'h140 || valid_IFID !== 1'b1 || pc_4_IFID !== 32'h44)
      begin errors++; $display("FAIL redir_load: got pc=%h inst=%h v=%b pc4=%h want 40/140/1/44", pc_IFID, instruction_IFID, valid_IFID, pc_4_IFID); end checks++;
  endtask
  task automatic test_flush_stall();
    stall_ID = 1'b1;
    flush_ID = 1'b1;
    @(negedge clk);
    if (instruction_IFID !== 32'h13 || valid_IFID !== 1'b0 || pc_IFID !== 32'h40)
      begin errors++; $display("FAIL flush_stall: got inst=%h v=%b pc=%h want 13/0/40", instruction_IFID, valid_IFID, pc_IFID); end checks++;
    flush_ID = 1'b0;
    @(negedge clk);
    if (pc_IFID !== 32'h44 || instruction_IFID !== 32'h144 || valid_IFID !== 1'b1)
      begin errors++; $display("FAIL stall_empty_load: got pc=%h inst=%h v=%b want 44/144/1", pc_IFID, instruction_IFID, valid_IFID); end checks++;
    stall_ID = 1'b0;
  endtask
  task automatic test_wrap();
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir: got addr=%h req=%b want fffffffc/0", imem_addr, imem_req); end checks++;
    redirect_en = 1'b0;
    repeat (3) @(negedge clk);
    if (pc_IFID !== 32'hFFFF_FFFC || pc_4_IFID !== 32'h0 || instruction_IFID !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL wrap_ifid: got pc=%h pc4=%h inst=%h want fffffffc/0/fffffffc", pc_IFID, pc_4_IFID, instruction_IFID); end checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got addr=%h req=%b want 0/1", imem_addr, imem_req); end checks++;
  endtask
  task automatic test_misalign();
    redirect_en = 1'b1;
    redirect_pc = 32'h42;
    @(negedge clk);
    if (imem_addr !== 32'h40) begin errors++; $display("FAIL mis_addr: got %h want 40", imem_addr); end checks++;
`ifdef IF_MISALIGN_TRAP_EN
    if (misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap: got %b want 1", misalign_trap); end checks++;
`endif
    redirect_en = 1'b0;
    @(negedge clk);
`ifdef IF_MISALIGN_TRAP_EN
    if (misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misalign_trap); end checks++;
`endif
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL mis_fetch: got req=%b addr=%h want 1/40", imem_req, imem_addr); end checks++;
  endtask
  task automatic test_flush_load();
    @(negedge clk);
    flush_ID = 1'b1;
    @(negedge clk);
    if (valid_IFID !== 1'b0 || instruction_IFID !== 32'h13 || pc_IFID !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL flush_load: got v=%b inst=%h pc=%h want 0/13/fffffffc", valid_IFID, instruction_IFID, pc_IFID); end checks++;
    if (imem_addr !== 32'h44 || imem_req !== 1'b1) begin errors++; $display("FAIL flush_adv: got addr=%h req=%b want 44/1", imem_addr, imem_req); end checks++;
    flush_ID = 1'b0;
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    imem_ready = 1'b0;
    mem_hold = 1'b1;
    reset = 1'b1;
    #1;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || valid_IFID !== 1'b0 || pc_4_IFID !== 32'h0)
      begin errors++; $display("FAIL mid_reset: got req=%b addr=%h v=%b pc4=%h want 0/0/0/0", imem_req, imem_addr, valid_IFID, pc_4_IFID); end checks++;
    @(negedge clk);
    reset = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_IFID !== 1'b0 || instruction_IFID !== 32'h13)
      begin errors++; $display("FAIL mid_ignore: got req=%b addr=%h v=%b inst=%h want 1/0/0/13", imem_req, imem_addr, valid_IFID, instruction_IFID); end checks++;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    if (pc_IFID !== 32'h0 || instruction_IFID !== 32'h100 || valid_IFID !== 1'b1)
      begin errors++; $display("FAIL mid_restart: got pc=%h inst=%h v=%b want 0/100/1", pc_IFID, instruction_IFID, valid_IFID); end checks++;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_wait();
    test_flush_stall();
    test_wrap();
    test_misalign();
    test_flush_load();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
